// File: rtl/modbus_tx_sequencer.sv
// rtl/modbus_tx_sequencer.sv - Modbus RTU TX frame sequencer: FIFO -> UART with optional CRC16 and inter-frame gap
//
// Purpose:
//   Pops frame_len payload bytes from the TX FIFO, hands each to the UART over
//   a valid/ready handshake, optionally appends the Modbus CRC16 (low byte
//   first), then holds the line silent for silence_ticks+1 cycles.
//   Optional feature macro: MODBUS_TX_CRC_EN (CRC register, CRC_LO/CRC_HI
//   states and CRC append are present only when defined).
//
// Ports:
//   clk            clock
//   n_reset        synchronous, active-high reset
//   start          one-cycle frame request, sampled only in IDLE
//   abort          terminate the current frame, go to GAP
//   frame_len      payload byte count, latched on start
//   silence_ticks  post-frame silence in clk cycles, latched on start
//   fifo_empty     FIFO empty flag
//   fifo_data      FIFO data_out, valid the cycle after fifo_rd_en
//   fifo_rd_en     FIFO pop (combinational)
//   tx_data        byte to the UART
//   tx_valid       tx_data valid
//   tx_ready       UART accepts the byte
//   busy           sequencer not idle
//   done           one-cycle pulse on the last GAP cycle
//   err_underrun   one-cycle pulse when the FIFO is empty mid-frame

module modbus_tx_sequencer #(
    parameter int DATA_W = 8,
    parameter int LEN_W  = 9,
    parameter int GAP_W  = 16
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [LEN_W-1:0]  frame_len,
    input  logic [GAP_W-1:0]  silence_ticks,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd_en,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic              err_underrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_SEND,
`ifdef MODBUS_TX_CRC_EN
        S_CRC_LO,
        S_CRC_HI,
`endif
        S_GAP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [LEN_W-1:0]  r_len;
    logic [GAP_W-1:0]  r_gap_q;
    logic [GAP_W-1:0]  r_gap_cnt;
    logic [DATA_W-1:0] r_tx_data;
    logic              w_send_hs;
    logic              w_last_byte;

`ifdef MODBUS_TX_CRC_EN
    logic [15:0] r_crc;
    logic [15:0] w_crc_next;

    // Reflected Modbus CRC16 (poly 0xA001), one full byte per call.
    function automatic logic [15:0] f_crc16_byte(input logic [15:0] crc,
                                                 input logic [DATA_W-1:0] data);
        logic [15:0] c;
        c = crc ^ 16'(data);
        for (int i = 0; i < DATA_W; i++) begin
            if (c[0]) begin
                c = (c >> 1) ^ 16'hA001;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    assign w_crc_next = f_crc16_byte(r_crc, r_tx_data);
`endif

    // A payload handshake only counts when the frame is not being aborted.
    assign w_send_hs   = (r_state == S_SEND) && tx_ready && !abort;
    assign w_last_byte = (r_len == LEN_W'(1));

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start && (frame_len != '0)) begin
                    w_next = S_FETCH;
                end
            end
            S_FETCH: begin
                if (abort || fifo_empty) begin
                    w_next = S_GAP;
                end else begin
                    w_next = S_LATCH;
                end
            end
            S_LATCH: begin
                w_next = abort ? S_GAP : S_SEND;
            end
            S_SEND: begin
                if (abort) begin
                    w_next = S_GAP;
                end else if (tx_ready) begin
`ifdef MODBUS_TX_CRC_EN
                    w_next = w_last_byte ? S_CRC_LO : S_FETCH;
`else
                    w_next = w_last_byte ? S_GAP : S_FETCH;
`endif
                end
            end
`ifdef MODBUS_TX_CRC_EN
            S_CRC_LO: begin
                if (abort) begin
                    w_next = S_GAP;
                end else if (tx_ready) begin
                    w_next = S_CRC_HI;
                end
            end
            S_CRC_HI: begin
                if (abort || tx_ready) begin
                    w_next = S_GAP;
                end
            end
`endif
            S_GAP: begin
                if (r_gap_cnt == '0) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (n_reset) begin
            r_state   <= S_IDLE;
            r_len     <= '0;
            r_gap_q   <= '0;
            r_gap_cnt <= '0;
            r_tx_data <= '0;
`ifdef MODBUS_TX_CRC_EN
            r_crc     <= 16'hFFFF;
`endif
        end else begin
            r_state <= w_next;

            if ((r_state == S_IDLE) && (w_next == S_FETCH)) begin
                r_len   <= frame_len;
                r_gap_q <= silence_ticks;
`ifdef MODBUS_TX_CRC_EN
                r_crc   <= 16'hFFFF;
`endif
            end

            if ((r_state == S_LATCH) && !abort) begin
                r_tx_data <= fifo_data;
            end

            // CRC only follows payload bytes; it stays frozen while the
            // CRC bytes themselves are on the wire.
            if (w_send_hs) begin
                r_len <= r_len - LEN_W'(1);
`ifdef MODBUS_TX_CRC_EN
                r_crc <= w_crc_next;
`endif
            end

            if ((w_next == S_GAP) && (r_state != S_GAP)) begin
                r_gap_cnt <= r_gap_q;
            end else if ((r_state == S_GAP) && (r_gap_cnt != '0)) begin
                r_gap_cnt <= r_gap_cnt - GAP_W'(1);
            end
        end
    end

    assign fifo_rd_en   = (r_state == S_FETCH) && !fifo_empty;
    assign err_underrun = (r_state == S_FETCH) && fifo_empty && !abort;
    assign busy         = (r_state != S_IDLE);
    assign done         = (r_state == S_GAP) && (r_gap_cnt == '0);

    always_comb begin
        tx_valid = 1'b0;
        tx_data  = r_tx_data;
        case (r_state)
            S_SEND: tx_valid = 1'b1;
`ifdef MODBUS_TX_CRC_EN
            S_CRC_LO: begin
                tx_valid = 1'b1;
                tx_data  = r_crc[7:0];
            end
            S_CRC_HI: begin
                tx_valid = 1'b1;
                tx_data  = r_crc[15:8];
            end
`endif
            default: tx_valid = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_modbus_tx_sequencer.sv
// tb/tb_modbus_tx_sequencer.sv - self-checking bench for modbus_tx_sequencer
module tb_modbus_tx_sequencer;

    logic       clk = 1'b0;
    logic       n_reset = 1'b1;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic [8:0] frame_len = '0;
    logic [15:0] silence_ticks = '0;
    logic       fifo_empty;
    logic [7:0] fifo_data = '0;
    logic       fifo_rd_en;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready = 1'b1;
    logic       busy;
    logic       done;
    logic       err_underrun;

    modbus_tx_sequencer #(.DATA_W(8), .LEN_W(9), .GAP_W(16)) dut (
        .clk(clk), .n_reset(n_reset), .start(start), .abort(abort),
        .frame_len(frame_len), .silence_ticks(silence_ticks),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data), .fifo_rd_en(fifo_rd_en),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .busy(busy), .done(done), .err_underrun(err_underrun)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // FIFO model with registered data_out
    logic [7:0] mem [256];
    logic [7:0] wr_ptr = '0;
    logic [7:0] rd_ptr = '0;
    assign fifo_empty = (rd_ptr == wr_ptr);
    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_data <= mem[rd_ptr];
            rd_ptr    <= rd_ptr + 8'd1;
        end
    end

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got 'h%0h expected 'h%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // scoreboard and monitor statistics
    logic [7:0] exp_q [$];
    int n_rd, n_und, n_done, hs_cnt, first_valid, last_evt, done_cyc;
    bit chk_hold = 1'b1;
    bit prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    task automatic clr_stats();
        n_rd = 0; n_und = 0; n_done = 0; hs_cnt = 0;
        first_valid = -1; last_evt = -1; done_cyc = -1;
    endtask

    always @(negedge clk) begin
        if (!n_reset) begin
            if (fifo_rd_en) n_rd++;
            if (err_underrun) begin n_und++; last_evt = cyc; end
            if (done) begin n_done++; done_cyc = cyc; end
            if (tx_valid && first_valid < 0) first_valid = cyc;
            if (chk_hold && prev_stall) begin
                chk("hold_valid", int'(tx_valid), 1);
                chk("hold_data", int'(tx_data), int'(prev_data));
            end
            if (tx_valid && tx_ready) begin
                hs_cnt++;
                last_evt = cyc;
                if (exp_q.size() == 0) begin
                    n_chk++; n_err++;
                    $display("FAIL byte_extra: got 'h%0h expected no byte (cycle %0d)", tx_data, cyc);
                end else begin
                    chk("byte", int'(tx_data), int'(exp_q.pop_front()));
                end
            end
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    function automatic logic [15:0] crc16(input logic [7:0] d [$]);
        logic [15:0] c = 16'hFFFF;
        foreach (d[k]) begin
            c ^= {8'h00, d[k]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

    typedef struct {
        int nfifo;
        int flen;
        int sil;
        bit fixed;
        int stall_idx;
        int stall_cyc;
    } vec_t;

    logic [7:0] fixed_b [6] = '{8'h01, 8'h03, 8'h00, 8'h00, 8'h00, 8'h01};

    task automatic flush_fifo();
        wr_ptr = rd_ptr;
    endtask

    // Preloads the FIFO and pushes the expected byte stream; returns the
    // number of payload bytes that will actually go out.
    task automatic load_frame(input vec_t v, output int nsend);
        logic [7:0] d [$];
        logic [15:0] c;
        for (int i = 0; i < v.nfifo; i++) begin
            d.push_back(v.fixed ? fixed_b[i] : 8'($urandom));
            mem[wr_ptr] = d[i];
            wr_ptr = wr_ptr + 8'd1;
        end
        nsend = (v.nfifo < v.flen) ? v.nfifo : v.flen;
        for (int i = 0; i < nsend; i++) exp_q.push_back(d[i]);
        while (d.size() > nsend) void'(d.pop_back());
`ifdef MODBUS_TX_CRC_EN
        if (nsend == v.flen) begin
            if (v.fixed) begin
                exp_q.push_back(8'h84);
                exp_q.push_back(8'h0A);
            end else begin
                c = crc16(d);
                exp_q.push_back(c[7:0]);
                exp_q.push_back(c[15:8]);
            end
        end
`endif
    endtask

    task automatic pulse_start(input int flen, input int sil, output int sc);
        @(posedge clk); #1;
        frame_len = 9'(flen);
        silence_ticks = 16'(sil);
        start = 1'b1;
        sc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic run_frame(input vec_t v, input string tag);
        int nsend, sc, stall_left, budget;
        clr_stats();
        load_frame(v, nsend);
        stall_left = v.stall_cyc;
        pulse_start(v.flen, v.sil, sc);
        budget = 0;
        while (n_done == 0 && budget < 3000) begin
            if (hs_cnt == v.stall_idx && tx_valid && stall_left > 0) begin
                tx_ready = 1'b0;
                stall_left--;
            end else begin
                tx_ready = 1'b1;
            end
            @(posedge clk); #1;
            budget++;
        end
        tx_ready = 1'b1;
        if (n_done == 0) begin
            n_chk++; n_err++;
            $display("FAIL %s_timeout: no done within %0d cycles", tag, budget);
        end
        chk({tag, "_latency"}, first_valid - sc, 3);
        chk({tag, "_bytes_left"}, exp_q.size(), 0);
        chk({tag, "_rd_count"}, n_rd, nsend);
        chk({tag, "_underrun"}, n_und, (v.nfifo < v.flen) ? 1 : 0);
        chk({tag, "_done_delay"}, done_cyc - last_evt, v.sil + 1);
        chk({tag, "_done_once"}, n_done, 1);
        chk({tag, "_idle_busy"}, int'(busy), 0);
        exp_q.delete();
        flush_fifo();
    endtask

    vec_t vecs [5];

    initial begin
        int sc, nsend, budget, a_cyc, total;
        vec_t v;

        vecs[0] = '{nfifo: 6, flen: 6, sil: 10, fixed: 1'b1, stall_idx: -1, stall_cyc: 0};
        vecs[1] = '{nfifo: 6, flen: 6, sil: 10, fixed: 1'b1, stall_idx: 2,  stall_cyc: 5};
        vecs[2] = '{nfifo: 2, flen: 4, sil: 5,  fixed: 1'b0, stall_idx: -1, stall_cyc: 0};
        vecs[3] = '{nfifo: 1, flen: 1, sil: 0,  fixed: 1'b0, stall_idx: -1, stall_cyc: 0};
        vecs[4] = '{nfifo: 5, flen: 3, sil: 3,  fixed: 1'b0, stall_idx: 0,  stall_cyc: 2};

        repeat (3) @(posedge clk);
        #1;
        n_reset = 1'b0;
        @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_valid", int'(tx_valid), 0);
        chk("rst_data", int'(tx_data), 0);
        chk("rst_rd_en", int'(fifo_rd_en), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_underrun", int'(err_underrun), 0);

        // frame_len==0 start is ignored
        clr_stats();
        mem[wr_ptr] = 8'h55; wr_ptr = wr_ptr + 8'd1;
        pulse_start(0, 4, sc);
        chk("len0_busy", int'(busy), 0);
        @(posedge clk); #1;
        chk("len0_rd", n_rd, 0);
        flush_fifo();

        for (int i = 0; i < 5; i++) begin
            run_frame(vecs[i], $sformatf("vec%0d", i));
        end

        // abort while byte 2 is presented
        chk_hold = 1'b0;
        clr_stats();
        v = '{nfifo: 6, flen: 6, sil: 7, fixed: 1'b0, stall_idx: -1, stall_cyc: 0};
        load_frame(v, nsend);
        while (exp_q.size() > 1) void'(exp_q.pop_back());
        pulse_start(6, 7, sc);
        budget = 0;
        tx_ready = 1'b1;
        while (!(hs_cnt == 1 && tx_valid) && budget < 200) begin
            tx_ready = (hs_cnt == 0);
            @(posedge clk); #1;
            budget++;
        end
        tx_ready = 1'b0;
        chk("abort_reached", int'(hs_cnt == 1 && tx_valid), 1);
        a_cyc = cyc;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        chk("abort_valid_drop", int'(tx_valid), 0);
        chk("abort_busy", int'(busy), 1);
        start = 1'b1; frame_len = 9'd6;
        @(posedge clk); #1;
        start = 1'b0;
        budget = 0;
        while (n_done == 0 && budget < 200) begin
            @(posedge clk); #1;
            budget++;
        end
        chk("abort_done_delay", done_cyc - a_cyc, 7 + 1);
        chk("abort_rd_count", n_rd, 2);
        chk("abort_no_underrun", n_und, 0);
        chk("abort_bytes_left", exp_q.size(), 0);
        chk("abort_gap_start_ignored", int'(busy), 0);
        @(posedge clk); #1;
        chk("abort_rd_after", n_rd, 2);
        tx_ready = 1'b1;
        exp_q.delete();
        flush_fifo();

        // reset during the final byte of a frame (CRC_HI when CRC is built in)
        clr_stats();
        v = '{nfifo: 6, flen: 6, sil: 10, fixed: 1'b1, stall_idx: -1, stall_cyc: 0};
        load_frame(v, nsend);
        total = exp_q.size();
        pulse_start(6, 10, sc);
        budget = 0;
        while (!(hs_cnt == total - 1 && tx_valid) && budget < 200) begin
            tx_ready = (hs_cnt != total - 1);
            @(posedge clk); #1;
            budget++;
        end
        tx_ready = 1'b0;
        chk("rstmid_reached", int'(hs_cnt == total - 1 && tx_valid), 1);
        n_reset = 1'b1;
        @(posedge clk); #1;
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_valid", int'(tx_valid), 0);
        chk("rstmid_data", int'(tx_data), 0);
        chk("rstmid_rd_en", int'(fifo_rd_en), 0);
        chk("rstmid_done", int'(done), 0);
        n_reset = 1'b0;
        tx_ready = 1'b1;
        exp_q.delete();
        flush_fifo();
        chk_hold = 1'b1;
        v = '{nfifo: 6, flen: 6, sil: 2, fixed: 1'b0, stall_idx: 1, stall_cyc: 3};
        run_frame(v, "post_rst");

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/modbus_tx_sequencer.md
Name: modbus_tx_sequencer

Overview:
Frame sequencer that drains the TX byte FIFO into the UART transmitter for Modbus RTU.
On a start command it pops frame_len payload bytes from the FIFO and presents each to the UART with a valid/ready handshake.
It optionally appends the Modbus CRC16 and then enforces the inter-frame silent interval before accepting the next frame.
It is the sole reader of the TX FIFO: it owns the FIFO's rd_en and consumes its registered data_out and empty outputs.

Parameters:
DATA_W, 8, byte width; fixed at 8 for Modbus.
LEN_W, 9, width of the frame_len input and of the internal remaining-byte counter.
GAP_W, 16, width of the silence_ticks input and of the gap counter.

Ports:
clk  input  1  clock.
n_reset  input  1  reset; synchronous, active-high.
start  input  1  one-cycle frame request; sampled only in IDLE.
abort  input  1  terminate the current frame; jump to GAP.
frame_len  input  LEN_W  payload bytes to pull from the FIFO; latched on start.
silence_ticks  input  GAP_W  post-frame silence in clk cycles; latched on start.
fifo_empty  input  1  FIFO empty flag.
fifo_data  input  DATA_W  FIFO data_out; valid the cycle after fifo_rd_en.
fifo_rd_en  output  1  FIFO pop.
tx_data  output  DATA_W  byte to the UART.
tx_valid  output  1  tx_data valid.
tx_ready  input  1  UART accepts the byte.
busy  output  1  state != IDLE.
done  output  1  one-cycle pulse when GAP completes.
err_underrun  output  1  one-cycle pulse when the FIFO is empty mid-frame.

Behaviour:
- Reset: state=IDLE; fifo_rd_en=0, tx_valid=0, tx_data=0, busy=0, done=0, err_underrun=0; crc=0xFFFF; counters=0.
- Reset mid-frame: sequencer returns to IDLE at the next edge. Unread FIFO bytes remain; the FIFO owner flushes them.
- IDLE:
  - start=1 with frame_len!=0: latch len_q, gap_q, and set crc=0xFFFF, then go to FETCH.
  - start with frame_len==0: ignored.
- FETCH:
  - fifo_rd_en = (state==FETCH) && !fifo_empty, driven combinationally. When asserted, go to LATCH.
  - fifo_empty=1 in FETCH: pulse err_underrun, go to GAP, no CRC sent.
- LATCH: capture fifo_data into tx_data, go to SEND.
- SEND:
  - tx_valid=1; tx_data held stable until tx_valid && tx_ready.
  - On handshake: crc updated with tx_data; len_q decremented.
  - If len_q was 1: go to CRC_LO (or GAP when the CRC is compiled out). Otherwise go to FETCH.
- CRC_LO: tx_data=crc[7:0], tx_valid=1 until handshake, then go to CRC_HI.
- CRC_HI: tx_data=crc[15:8], tx_valid=1 until handshake, then go to GAP.
  - The CRC value is frozen after the last payload byte; CRC bytes do not update it.
- GAP:
  - Counter loads gap_q on entry and decrements each cycle.
  - When the counter is 0: pulse done, go to IDLE.
  - silence_ticks=0 gives one GAP cycle.
  - start during GAP is ignored, since it is sampled only in IDLE.
- abort=1 in FETCH/LATCH/SEND/CRC_LO/CRC_HI:
  - Go to GAP next edge; tx_valid=0 next cycle; err_underrun not pulsed.
  - A byte popped but not yet sent is discarded.
  - abort in IDLE or GAP has no effect.
- Latency: start sampled at cycle 0 → fifo_rd_en at cycle 1 → tx_valid at cycle 3. Per byte with tx_ready=1: 3 cycles.
- CRC: Modbus CRC16, reflected polynomial 0xA001, init 0xFFFF, eight shift/xor iterations per byte in one cycle; transmitted low byte first.
- Priority in any cycle: n_reset > abort > normal transitions.

Optional Feature:
MODBUS_TX_CRC_EN.
- Defined: the CRC register, the CRC_LO/CRC_HI states and the CRC append are present; each frame is frame_len+2 bytes.
- Undefined: no CRC logic and no CRC states; the frame is exactly frame_len bytes and goes SEND→GAP after the last byte.

Test Plan:
1. CRC enabled; FIFO preloaded 01 03 00 00 00 01; frame_len=6, silence_ticks=10, tx_ready=1 → tx bytes 01 03 00 00 00 01 84 0A in order; fifo_rd_en pulsed exactly 6 times; done pulses 11 cycles after the 0A handshake.
2. As scenario 1 but tx_ready low for 5 cycles on byte 3 → tx_data=00 held stable and tx_valid=1 throughout; same 8-byte sequence, same CRC 84 0A.
3. FIFO holds 2 bytes, frame_len=4 → 2 bytes sent; err_underrun pulses once in the third FETCH; no CRC bytes; done follows the GAP.
4. abort asserted while tx_valid=1 on byte 2 of a 6-byte frame → tx_valid=0 next cycle; no further fifo_rd_en; done after silence_ticks+1 cycles; the next start is accepted only after done.
5. n_reset asserted in CRC_HI → next cycle all outputs are at reset values and busy=0; a new start with a fresh frame produces correct bytes and CRC starting from init 0xFFFF.
6. Compile without MODBUS_TX_CRC_EN, same stimulus as scenario 1 → exactly 6 bytes sent, no 84 0A; done follows the GAP.
